// File: rtl/router_merge_4to1_if.sv
// Handshake bundle for the 4-to-1 merge: four valid/ready input streams
// and one tagged valid/ready output stream.
// slave  : the merge block itself.
// master : the environment that feeds the inputs and drains the output.
interface router_merge_4to1_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] din0;
  logic [DATA_WIDTH-1:0] din1;
  logic [DATA_WIDTH-1:0] din2;
  logic [DATA_WIDTH-1:0] din3;
  logic                  valid_in0;
  logic                  valid_in1;
  logic                  valid_in2;
  logic                  valid_in3;
  logic                  ready_out0;
  logic                  ready_out1;
  logic                  ready_out2;
  logic                  ready_out3;
  logic [DATA_WIDTH-1:0] dout;
  logic [1:0]            src_id;
  logic                  valid_out;
  logic                  ready_in;

  modport slave (
    input  din0, din1, din2, din3,
    input  valid_in0, valid_in1, valid_in2, valid_in3,
    output ready_out0, ready_out1, ready_out2, ready_out3,
    output dout, src_id, valid_out,
    input  ready_in
  );

  modport master (
    output din0, din1, din2, din3,
    output valid_in0, valid_in1, valid_in2, valid_in3,
    input  ready_out0, ready_out1, ready_out2, ready_out3,
    input  dout, src_id, valid_out,
    output ready_in
  );
endinterface

// File: rtl/router_merge_4to1.sv
// 4-to-1 merge/arbiter with a single registered, source-tagged output stage.
// Round-robin arbitration by default; one word per cycle throughput.
// Build option ROUTER_MERGE_FIXED_PRI_EN: fixed priority 0>1>2>3 instead of
// round-robin (the rotating pointer is then removed).
module router_merge_4to1 #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  router_merge_4to1_if.slave    bus
);

  logic [3:0]            vin;
  logic [DATA_WIDTH-1:0] din_arr [4];
  logic [1:0]            grant;
  logic                  any_valid;
  logic                  load;
  logic [DATA_WIDTH-1:0] dout_q;
  logic [1:0]            src_id_q;
  logic                  valid_out_q;

  assign vin        = {bus.valid_in3, bus.valid_in2, bus.valid_in1, bus.valid_in0};
  assign din_arr[0] = bus.din0;
  assign din_arr[1] = bus.din1;
  assign din_arr[2] = bus.din2;
  assign din_arr[3] = bus.din3;

  // The output register may take a new word when empty or being drained.
  assign load = !valid_out_q || bus.ready_in;

`ifdef ROUTER_MERGE_FIXED_PRI_EN
  // Fixed priority: lowest-numbered valid port wins.
  always_comb begin
    grant     = 2'd0;
    any_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (!any_valid && vin[i]) begin
        grant     = 2'(i);
        any_valid = 1'b1;
      end
    end
  end
`else
  logic [1:0] last_gnt;

  // Round-robin: search from the port after the last winner, wrapping mod 4,
  // so the last winner is considered last.
  always_comb begin
    logic [1:0] idx;
    grant     = 2'd0;
    any_valid = 1'b0;
    idx       = 2'd0;
    for (int i = 1; i <= 4; i++) begin
      idx = last_gnt + 2'(i);
      if (!any_valid && vin[idx]) begin
        grant     = idx;
        any_valid = 1'b1;
      end
    end
  end

  // Pointer moves only when a word is actually accepted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_gnt <= 2'd3;
    end else if (load && any_valid) begin
      last_gnt <= grant;
    end
  end
`endif

  assign bus.ready_out0 = load && any_valid && (grant == 2'd0);
  assign bus.ready_out1 = load && any_valid && (grant == 2'd1);
  assign bus.ready_out2 = load && any_valid && (grant == 2'd2);
  assign bus.ready_out3 = load && any_valid && (grant == 2'd3);

  // Output stage: capture the granted word, or go idle keeping the last data/tag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dout_q      <= '0;
      src_id_q    <= 2'd0;
      valid_out_q <= 1'b0;
    end else if (load) begin
      if (any_valid) begin
        dout_q      <= din_arr[grant];
        src_id_q    <= grant;
        valid_out_q <= 1'b1;
      end else begin
        valid_out_q <= 1'b0;
      end
    end
  end

  assign bus.dout      = dout_q;
  assign bus.src_id    = src_id_q;
  assign bus.valid_out = valid_out_q;

endmodule

// File: tb/tb_router_merge_4to1.sv
// Directed bench for router_merge_4to1: reset, single port, round-robin
// rotation, backpressure, sparse inputs, priority mode and idle behaviour.
module tb_router_merge_4to1;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;

  router_merge_4to1_if #(.DATA_WIDTH(8)) bus ();

  router_merge_4to1 #(.DATA_WIDTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [3:0] rdy_vec();
    return {bus.ready_out3, bus.ready_out2, bus.ready_out1, bus.ready_out0};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs are changed and outputs sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic [3:0] v, input logic [7:0] d0, input logic [7:0] d1,
                        input logic [7:0] d2, input logic [7:0] d3);
    {bus.valid_in3, bus.valid_in2, bus.valid_in1, bus.valid_in0} = v;
    bus.din0 = d0;
    bus.din1 = d1;
    bus.din2 = d2;
    bus.din3 = d3;
  endtask

  initial begin
    logic [1:0] exp_port;
    logic [1:0] seq6 [4];
    n_checks = 0;
    n_errors = 0;
    rst          = 1'b1;
    bus.ready_in = 1'b0;
    set_in(4'b0000, 8'h00, 8'h00, 8'h00, 8'h00);
    repeat (2) tick();
    chk("rst_valid_out", 32'(bus.valid_out), 32'd0);
    chk("rst_dout",      32'(bus.dout),      32'd0);
    chk("rst_src_id",    32'(bus.src_id),    32'd0);
    rst = 1'b0;
    tick();

    // Single port 2
    set_in(4'b0100, 8'h00, 8'h00, 8'hA5, 8'h00);
    bus.ready_in = 1'b1;
    #1;
    chk("single_ready", 32'(rdy_vec()), 32'b0100);
    tick();
    chk("single_valid", 32'(bus.valid_out), 32'd1);
    chk("single_dout",  32'(bus.dout),      32'hA5);
    chk("single_src",   32'(bus.src_id),    32'd2);

    // Reset while a word is held: outputs clear asynchronously
    set_in(4'b0000, 8'h00, 8'h00, 8'h00, 8'h00);
    bus.ready_in = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk("arst_valid_out", 32'(bus.valid_out), 32'd0);
    chk("arst_dout",      32'(bus.dout),      32'd0);
    chk("arst_src_id",    32'(bus.src_id),    32'd0);
    tick();
    rst = 1'b0;
    tick();

    // All ports valid: rotation 0,1,2,3,0,1 starting from port 0 after reset
    bus.ready_in = 1'b1;
    for (int k = 0; k < 6; k++) begin
      exp_port = 2'(k % 4);
      set_in(4'b1111, 8'(8'h00 + k), 8'(8'h10 + k), 8'(8'h20 + k), 8'(8'h30 + k));
      #1;
      chk("rr_ready", 32'(rdy_vec()), 32'(4'b0001 << exp_port));
      tick();
      chk("rr_src",  32'(bus.src_id), 32'(exp_port));
      chk("rr_dout", 32'(bus.dout),   32'(exp_port) * 16 + 32'(k));
    end

    // Backpressure: held word 0x15 from port 1 stays put, no ready_out
    bus.ready_in = 1'b0;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("bp_ready", 32'(rdy_vec()), 32'd0);
      tick();
      chk("bp_valid", 32'(bus.valid_out), 32'd1);
      chk("bp_dout",  32'(bus.dout),      32'h15);
      chk("bp_src",   32'(bus.src_id),    32'd1);
    end
    bus.ready_in = 1'b1;
    #1;
`ifdef ROUTER_MERGE_FIXED_PRI_EN
    chk("bp_release_ready", 32'(rdy_vec()), 32'b0001);
    tick();
    chk("bp_release_src", 32'(bus.src_id), 32'd0);
    chk("bp_release_dout", 32'(bus.dout), 32'h05);
`else
    chk("bp_release_ready", 32'(rdy_vec()), 32'b0100);
    tick();
    chk("bp_release_src", 32'(bus.src_id), 32'd2);
    chk("bp_release_dout", 32'(bus.dout), 32'h25);
`endif

    // Sparse: prime pointer to 1 via a port-1 transfer, then ports 1 and 3 valid
    set_in(4'b0010, 8'h00, 8'h31, 8'h00, 8'h00);
    #1;
    chk("sp_prime_ready", 32'(rdy_vec()), 32'b0010);
    tick();
    chk("sp_prime_src", 32'(bus.src_id), 32'd1);
    set_in(4'b1010, 8'h00, 8'h41, 8'h00, 8'h43);
    #1;
`ifdef ROUTER_MERGE_FIXED_PRI_EN
    chk("sp1_ready", 32'(rdy_vec()), 32'b0010);
    tick();
    chk("sp1_src", 32'(bus.src_id), 32'd1);
    chk("sp1_dout", 32'(bus.dout), 32'h41);
`else
    chk("sp1_ready", 32'(rdy_vec()), 32'b1000);
    tick();
    chk("sp1_src", 32'(bus.src_id), 32'd3);
    chk("sp1_dout", 32'(bus.dout), 32'h43);
    set_in(4'b1010, 8'h00, 8'h41, 8'h00, 8'h53);
    #1;
    chk("sp2_ready", 32'(rdy_vec()), 32'b0010);
    tick();
    chk("sp2_src", 32'(bus.src_id), 32'd1);
    chk("sp2_dout", 32'(bus.dout), 32'h41);
    set_in(4'b1010, 8'h00, 8'h61, 8'h00, 8'h53);
    #1;
    chk("sp3_ready", 32'(rdy_vec()), 32'b1000);
    tick();
    chk("sp3_src", 32'(bus.src_id), 32'd3);
    chk("sp3_dout", 32'(bus.dout), 32'h53);
`endif

    // Ports 0 and 3 valid: alternate under round-robin, port 0 only under fixed priority
`ifdef ROUTER_MERGE_FIXED_PRI_EN
    seq6[0] = 2'd0; seq6[1] = 2'd0; seq6[2] = 2'd0; seq6[3] = 2'd0;
`else
    seq6[0] = 2'd0; seq6[1] = 2'd3; seq6[2] = 2'd0; seq6[3] = 2'd3;
`endif
    set_in(4'b1001, 8'h0A, 8'h00, 8'h00, 8'h3A);
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("p03_ready", 32'(rdy_vec()), 32'(4'b0001 << seq6[k]));
      tick();
      chk("p03_src", 32'(bus.src_id), 32'(seq6[k]));
    end

    // Idle with ready_in high: valid_out drops, data and tag hold, pointer unchanged
    set_in(4'b0000, 8'h00, 8'h00, 8'h00, 8'h00);
    #1;
    chk("idle_ready", 32'(rdy_vec()), 32'd0);
    tick();
    chk("idle_valid", 32'(bus.valid_out), 32'd0);
    chk("idle_src",   32'(bus.src_id),    32'(seq6[3]));
    chk("idle_dout",  32'(bus.dout),      32'(seq6[3] == 2'd3 ? 8'h3A : 8'h0A));
    tick();
    set_in(4'b1001, 8'h0B, 8'h00, 8'h00, 8'h3B);
    #1;
    chk("post_idle_ready", 32'(rdy_vec()), 32'b0001);
    tick();
    chk("post_idle_src",  32'(bus.src_id), 32'd0);
    chk("post_idle_dout", 32'(bus.dout),   32'h0B);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
